comp_weight_pingpong_buffer: RTL and testbench

Parametrised, double-buffered successor to the column compensation memory.
- Accepts a serial stream of compensation weights over a valid/ready handshake and fills one bank in column-major order.
- Streams the other bank out one row per beat: all SIZE columns in parallel, to the systolic array pre-load path.
- Ping-pong banking lets loading the next tile overlap with consuming the current one.

---
 rtl/comp_weight_pingpong_buffer_pkg.sv | 14 +
 rtl/comp_weight_pingpong_buffer_bank_ram.sv | 54 +++++
 rtl/comp_weight_pingpong_buffer.sv | 170 +++++++++++++++++
 tb/tb_comp_weight_pingpong_buffer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_weight_pingpong_buffer_pkg.sv
// Shared definitions for the double-buffered column compensation weight store.
package comp_weight_pingpong_buffer_pkg;

    localparam int NUM_BANKS = 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Index width that never collapses to zero bits for single-entry dimensions.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/comp_weight_pingpong_buffer_bank_ram.sv
// One compensation bank: SIZE columns x DEPTH rows, single-entry write port,
// row-wide combinational read port presenting every column of one row.
module comp_bank_ram
    import comp_weight_pingpong_buffer_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int DEPTH    = 3,
    parameter int CW_WIDTH = 4,
    parameter int ROW_W    = clog2_min1(DEPTH),
    parameter int COL_W    = clog2_min1(SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [COL_W-1:0]         wr_col,
    input  logic [ROW_W-1:0]         wr_row,
    input  logic [CW_WIDTH-1:0]      wr_data,
    input  logic [ROW_W-1:0]         rd_row,
    output logic [SIZE*CW_WIDTH-1:0] rd_data
);

    logic [CW_WIDTH-1:0] mem [SIZE][DEPTH];

    // Address decode by comparison keeps non power-of-two dimensions safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < SIZE; c++) begin
                for (int r = 0; r < DEPTH; r++) begin
                    mem[c][r] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int c = 0; c < SIZE; c++) begin
                for (int r = 0; r < DEPTH; r++) begin
                    if (wr_col == COL_W'(c) && wr_row == ROW_W'(r)) begin
                        mem[c][r] <= wr_data;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < SIZE; c++) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (rd_row == ROW_W'(r)) begin
                    rd_data[c*CW_WIDTH +: CW_WIDTH] = mem[c][r];
                end
            end
        end
    end

endmodule

// File: rtl/comp_weight_pingpong_buffer.sv
// Ping-pong compensation weight buffer: serial column-major fill of one bank while
// the other streams out one full row per beat; banks are consumed in fill order.
module comp_weight_pingpong_buffer
    import comp_weight_pingpong_buffer_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int DEPTH    = 3,
    parameter int CW_WIDTH = 4,
    parameter int ROW_W    = clog2_min1(DEPTH),
    parameter int COL_W    = clog2_min1(SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [CW_WIDTH-1:0]      wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     rd_start,
    output logic                     rd_busy,
    output logic [SIZE*CW_WIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW_W-1:0]         out_row,
    output logic                     out_last,
    output logic [NUM_BANKS-1:0]     bank_full
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SIZE - 1);

    logic [0:0]                 state;
    logic                       wr_bank;
    logic                       rd_bank;
    logic [ROW_W-1:0]           wr_row;
    logic [COL_W-1:0]           wr_col;
    logic [ROW_W-1:0]           rd_row;
    logic                       rd_issued;
    logic [NUM_BANKS-1:0]       bank_full_nxt;
    logic [SIZE*CW_WIDTH-1:0]   bank_rd_data [NUM_BANKS];

    logic wr_fire;
    logic fill_done;
    logic start_fire;
    logic load_row;
    logic release_bank;

    assign wr_ready     = !bank_full[wr_bank];
    assign rd_busy      = (state == ST_STREAM);
    assign wr_fire      = wr_valid && wr_ready;
    assign fill_done    = wr_fire && (wr_row == ROW_LAST) && (wr_col == COL_LAST);
    assign start_fire   = (state == ST_IDLE) && rd_start && bank_full[rd_bank];
    assign load_row     = (state == ST_STREAM) && !rd_issued && (!out_valid || out_ready);
    assign release_bank = out_valid && out_ready && out_last;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        comp_bank_ram #(
            .SIZE     (SIZE),
            .DEPTH    (DEPTH),
            .CW_WIDTH (CW_WIDTH),
            .ROW_W    (ROW_W),
            .COL_W    (COL_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_fire && (wr_bank == 1'(b))),
            .wr_col  (wr_col),
            .wr_row  (wr_row),
            .wr_data (wr_data),
            .rd_row  (rd_row),
            .rd_data (bank_rd_data[b])
        );
    end

    // A fill and a release never target the same bank in one cycle: the write
    // side stalls on a full bank, so wr_ready only recovers after the release.
    always_comb begin
        bank_full_nxt = bank_full;
        if (release_bank) bank_full_nxt[rd_bank] = 1'b0;
        if (fill_done)    bank_full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= '0;
        end else if (clear) begin
            bank_full <= '0;
        end else begin
            bank_full <= bank_full_nxt;
        end
    end

    // Column-major write addressing: row runs fastest, bank flips after the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
        end else if (clear) begin
            wr_bank <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
        end else if (wr_fire) begin
            if (wr_row == ROW_LAST) begin
                wr_row <= '0;
                if (wr_col == COL_LAST) begin
                    wr_col  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end else begin
                wr_row <= wr_row + ROW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_bank   <= 1'b0;
            rd_row    <= '0;
            rd_issued <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            rd_bank   <= 1'b0;
            rd_row    <= '0;
            rd_issued <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_fire) begin
                        state     <= ST_STREAM;
                        rd_row    <= '0;
                        rd_issued <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (load_row) begin
                        out_data  <= bank_rd_data[rd_bank];
                        out_row   <= rd_row;
                        out_last  <= (rd_row == ROW_LAST);
                        out_valid <= 1'b1;
                        if (rd_row == ROW_LAST) begin
                            rd_issued <= 1'b1;
                        end else begin
                            rd_row <= rd_row + ROW_W'(1);
                        end
                    end
                    // rd_issued guarantees no new load can coincide with the final handshake.
                    if (release_bank) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rd_bank   <= ~rd_bank;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_weight_pingpong_buffer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and
// randomized traffic against a tile-queue reference model.
module tb_comp_weight_pingpong_buffer;

    localparam int SIZE  = 8;
    localparam int DEPTH = 3;
    localparam int CW    = 4;
    localparam int ROW_W = 2;
    localparam int COL_W = 3;
    localparam int NT    = SIZE * DEPTH;
    localparam int OW    = SIZE * CW;
    localparam int IW    = 5;
    localparam int NV    = NT + 5;

    typedef logic [NT-1:0][CW-1:0] tile_t;

    typedef struct {
        logic             wr_valid;
        logic [CW-1:0]    wr_data;
        logic             rd_start;
        logic             out_ready;
        logic             exp_wr_ready;
        logic [1:0]       exp_bank_full;
        logic             exp_busy;
        logic             exp_out_valid;
        logic [ROW_W-1:0] exp_row;
        logic             exp_last;
        logic [OW-1:0]    exp_data;
        logic             chk_data;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [CW-1:0]    wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             rd_start;
    logic             rd_busy;
    logic [OW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_row;
    logic             out_last;
    logic [1:0]       bank_full;

    int checks = 0;
    int errors = 0;

    comp_weight_pingpong_buffer #(
        .SIZE     (SIZE),
        .DEPTH    (DEPTH),
        .CW_WIDTH (CW),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_start  (rd_start),
        .rd_busy   (rd_busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane c of row r holds the entry written at column-major position c*DEPTH + r.
    function automatic logic [OW-1:0] row_of(input tile_t t, input int r);
        logic [OW-1:0] res;
        res = '0;
        for (int c = 0; c < SIZE; c++) begin
            res = res | (OW'(t[IW'(c*DEPTH + r)]) << (c*CW));
        end
        return res;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int i = 0; i < NT; i++) t[IW'(i)] = CW'($urandom);
        return t;
    endfunction

    function automatic vec_t mk(input logic wv, input logic [CW-1:0] wd, input logic rs,
                                input logic ordy, input logic ewr, input logic [1:0] ebf,
                                input logic eb, input logic eov, input int er,
                                input logic el, input logic cd, input tile_t t);
        vec_t v;
        v.wr_valid      = wv;
        v.wr_data       = wd;
        v.rd_start      = rs;
        v.out_ready     = ordy;
        v.exp_wr_ready  = ewr;
        v.exp_bank_full = ebf;
        v.exp_busy      = eb;
        v.exp_out_valid = eov;
        v.exp_row       = ROW_W'(er);
        v.exp_last      = el;
        v.exp_data      = cd ? row_of(t, er) : '0;
        v.chk_data      = cd;
        return v;
    endfunction

    task automatic do_reset();
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_start  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        rst       = 1'b1;
        #7;
        rst = 1'b0;
        tick();
    endtask

    task automatic write_tile(input tile_t t, input string name);
        for (int i = 0; i < NT; i++) begin
            wr_valid = 1'b1;
            wr_data  = t[IW'(i)];
            check({name, "_wr_ready"}, 64'(wr_ready), 64'(1));
            tick();
        end
        wr_valid = 1'b0;
    endtask

    // One streaming pass; optionally withholds out_ready for stall_n cycles once row stall_row shows.
    task automatic read_pass(input tile_t t, input int stall_row, input int stall_n,
                             input string name, output logic wr_rdy_last);
        int beat;
        int stalls;
        int budget;
        logic [OW-1:0]    hd;
        logic [ROW_W-1:0] hr;
        beat        = 0;
        stalls      = stall_n;
        budget      = 40;
        wr_rdy_last = 1'bx;
        rd_start    = 1'b1;
        out_ready   = 1'b1;
        tick();
        rd_start = 1'b0;
        check({name, "_busy"}, 64'(rd_busy), 64'(1));
        while (beat < DEPTH && budget > 0) begin
            budget--;
            if (stalls > 0 && out_valid && out_row == ROW_W'(stall_row)) begin
                hd        = out_data;
                hr        = out_row;
                out_ready = 1'b0;
                for (int s = 0; s < stalls; s++) begin
                    tick();
                    check({name, "_hold_valid"}, 64'(out_valid), 64'(1));
                    check({name, "_hold_data"}, 64'(out_data), 64'(hd));
                    check({name, "_hold_row"}, 64'(out_row), 64'(hr));
                end
                stalls    = 0;
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                check({name, "_row"}, 64'(out_row), 64'(beat));
                check({name, "_last"}, 64'(out_last), 64'(beat == DEPTH-1));
                check({name, "_data"}, 64'(out_data), 64'(row_of(t, beat)));
                if (beat == DEPTH-1) wr_rdy_last = wr_ready;
                beat++;
            end
            tick();
        end
        check({name, "_beats"}, 64'(beat), 64'(DEPTH));
        check({name, "_valid_after"}, 64'(out_valid), 64'(0));
        check({name, "_busy_after"}, 64'(rd_busy), 64'(0));
    endtask

    vec_t  vecs [NV];
    tile_t t0, ta, tb, tc, cur;
    tile_t tiles [$];
    logic  wl;
    logic [1:0] bf;
    int fills, cons, n, rbeat, age, avail, beat, budget, rd_pct;
    bit busy, bpre;

    initial begin
        for (int i = 0; i < NT; i++) t0[IW'(i)] = CW'(i);
        for (int i = 0; i < NT; i++)
            vecs[i] = mk(1, CW'(i), 0, 0, 1, (i == NT-1) ? 2'b01 : 2'b00, 0, 0, 0, 0, 0, t0);
        vecs[NT]   = mk(0, 0, 1, 1, 1, 2'b01, 1, 0, 0, 0, 0, t0);
        vecs[NT+1] = mk(0, 0, 0, 1, 1, 2'b01, 1, 1, 0, 0, 1, t0);
        vecs[NT+2] = mk(0, 0, 0, 1, 1, 2'b01, 1, 1, 1, 0, 1, t0);
        vecs[NT+3] = mk(0, 0, 0, 1, 1, 2'b01, 1, 1, 2, 1, 1, t0);
        vecs[NT+4] = mk(0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, t0);

        // Reset state while rst is held
        wr_valid = 1'b0; wr_data = '0; rd_start = 1'b0; out_ready = 1'b0; clear = 1'b0;
        rst = 1'b1;
        #3;
        check("rst_wr_ready", 64'(wr_ready), 64'(1));
        check("rst_bank_full", 64'(bank_full), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(rd_busy), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_row_last", 64'({out_row, out_last}), 64'(0));
        do_reset();

        // Directed fill and single pass from the vector table
        for (int i = 0; i < NV; i++) begin
            wr_valid  = vecs[i].wr_valid;
            wr_data   = vecs[i].wr_data;
            rd_start  = vecs[i].rd_start;
            out_ready = vecs[i].out_ready;
            tick();
            check($sformatf("vec%0d_wr_ready", i), 64'(wr_ready), 64'(vecs[i].exp_wr_ready));
            check($sformatf("vec%0d_bank_full", i), 64'(bank_full), 64'(vecs[i].exp_bank_full));
            check($sformatf("vec%0d_busy", i), 64'(rd_busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_row", i), 64'(out_row), 64'(vecs[i].exp_row));
                check($sformatf("vec%0d_last", i), 64'(out_last), 64'(vecs[i].exp_last));
                check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_data));
            end
        end
        wr_valid = 1'b0; out_ready = 1'b0;

        // rd_start with nothing full is ignored
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("illegal_busy", 64'(rd_busy), 64'(0));
        check("illegal_valid", 64'(out_valid), 64'(0));
        tick();
        check("illegal_valid2", 64'(out_valid | rd_busy), 64'(0));

        // Overlap: fill the second bank while the first streams
        do_reset();
        ta = rand_tile(); tb = rand_tile();
        write_tile(ta, "ovl_a");
        rd_start = 1'b1; out_ready = 1'b1; beat = 0;
        for (int i = 0; i < NT; i++) begin
            wr_valid = 1'b1;
            wr_data  = tb[IW'(i)];
            check("ovl_wr_ready", 64'(wr_ready), 64'(1));
            if (out_valid && out_ready) begin
                check("ovl_row", 64'(out_row), 64'(beat));
                check("ovl_data", 64'(out_data), 64'(row_of(ta, beat)));
                beat++;
            end
            tick();
            rd_start = 1'b0;
        end
        wr_valid = 1'b0;
        check("ovl_beats", 64'(beat), 64'(DEPTH));
        check("ovl_bank_full", 64'(bank_full), 64'(2'b10));
        read_pass(tb, -1, 0, "ovl_b", wl);
        check("ovl_bank_full_end", 64'(bank_full), 64'(0));

        // Both banks full: write stalls, extra value dropped, ready returns after release
        do_reset();
        ta = rand_tile(); tb = rand_tile(); tc = rand_tile();
        write_tile(ta, "full_a");
        write_tile(tb, "full_b");
        check("full_wr_ready", 64'(wr_ready), 64'(0));
        check("full_bank_full", 64'(bank_full), 64'(2'b11));
        wr_valid = 1'b1; wr_data = ~tc[0];
        tick();
        wr_valid = 1'b0;
        check("full_wr_ready2", 64'(wr_ready), 64'(0));
        read_pass(ta, -1, 0, "full_ra", wl);
        check("full_wr_ready_at_last", 64'(wl), 64'(0));
        check("full_wr_ready_after", 64'(wr_ready), 64'(1));
        check("full_bank_full_after", 64'(bank_full), 64'(2'b10));
        read_pass(tb, -1, 0, "full_rb", wl);
        write_tile(tc, "full_c");
        read_pass(tc, -1, 0, "full_rc", wl);

        // Backpressure in the middle of row 1
        do_reset();
        ta = rand_tile();
        write_tile(ta, "bp");
        read_pass(ta, 1, 5, "bp", wl);

        // clear while row 1 is on the output, with a partial fill pending
        do_reset();
        ta = rand_tile(); tc = rand_tile();
        write_tile(ta, "clr_a");
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = CW'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        rd_start = 1'b1; out_ready = 1'b1; budget = 10;
        do begin
            tick();
            rd_start = 1'b0;
            budget--;
        end while (!(out_valid && out_row == 2'd1) && budget > 0);
        check("clr_reached_row1", 64'(out_valid && out_row == 2'd1), 64'(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_out_valid", 64'(out_valid), 64'(0));
        check("clr_bank_full", 64'(bank_full), 64'(0));
        check("clr_wr_ready", 64'(wr_ready), 64'(1));
        check("clr_busy", 64'(rd_busy), 64'(0));
        write_tile(tc, "clr_c");
        read_pass(tc, -1, 0, "clr_rc", wl);

        // Asynchronous reset mid-fill and mid-stream acts without a clock edge
        do_reset();
        ta = rand_tile(); tc = rand_tile();
        write_tile(ta, "arst_a");
        rd_start = 1'b1; out_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1; wr_data = CW'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        check("arst_pre_valid", 64'(out_valid), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_busy", 64'(rd_busy), 64'(0));
        check("arst_bank_full", 64'(bank_full), 64'(0));
        check("arst_out_data", 64'(out_data), 64'(0));
        #3;
        rst = 1'b0;
        tick();
        write_tile(tc, "arst_c");
        read_pass(tc, -1, 0, "arst_rc", wl);

        // Randomized traffic against a queue-of-tiles model
        do_reset();
        fills = 0; cons = 0; n = 0; rbeat = 0; age = 0; busy = 0;
        tiles.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rd_pct    = (cyc < 2000) ? 3 : 30;
            wr_valid  = ($urandom_range(0, 99) < 60);
            wr_data   = CW'($urandom);
            rd_start  = ($urandom_range(0, 99) < rd_pct);
            out_ready = ($urandom_range(0, 99) < 70);
            clear     = ($urandom_range(0, 399) == 0);
            avail = fills - cons;
            bpre  = busy;
            bf    = 2'b00;
            for (int k = cons; k < fills; k++) bf[k[0]] = 1'b1;
            check("rnd_wr_ready", 64'(wr_ready), 64'(avail < 2));
            check("rnd_bank_full", 64'(bank_full), 64'(bf));
            check("rnd_busy", 64'(rd_busy), 64'(busy));
            if (!busy) check("rnd_idle_valid", 64'(out_valid), 64'(0));
            else if (age >= 1) check("rnd_stream_valid", 64'(out_valid), 64'(1));
            if (clear) begin
                fills = 0; cons = 0; n = 0; busy = 0; rbeat = 0; age = 0;
                tiles.delete();
            end else begin
                if (out_valid && out_ready && busy && tiles.size() > 0) begin
                    check("rnd_row", 64'(out_row), 64'(rbeat));
                    check("rnd_last", 64'(out_last), 64'(rbeat == DEPTH-1));
                    check("rnd_data", 64'(out_data), 64'(row_of(tiles[0], rbeat)));
                    if (rbeat == DEPTH-1) begin
                        void'(tiles.pop_front());
                        cons++;
                        busy  = 0;
                        rbeat = 0;
                    end else begin
                        rbeat++;
                    end
                end
                if (wr_valid && avail < 2) begin
                    cur[IW'(n)] = wr_data;
                    n++;
                    if (n == NT) begin
                        tiles.push_back(cur);
                        fills++;
                        n = 0;
                    end
                end
                if (rd_start && !bpre && avail >= 1) begin
                    busy = 1; rbeat = 0; age = 0;
                end else if (busy) begin
                    age++;
                end
            end
            tick();
        end
        clear = 1'b0; wr_valid = 1'b0; rd_start = 1'b0; out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
